bin_to_bcd_converter: RTL and testbench



---
 rtl/calc_pkg.sv | 14 +
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/bin_to_bcd_converter.sv | 106 ++++++++++
 tb/tb_bin_to_bcd_converter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator display-path definitions: default widths and converter state encoding.
// Also used by output_driver, so keep the encoding stable.
package calc_pkg;

  localparam int unsigned CALC_DATA_WIDTH = 16;
  localparam int unsigned CALC_NUM_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// valid/ready handshakes on both sides and an optional 2's-complement sign split.
module bin_to_bcd_converter
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CALC_DATA_WIDTH,
  parameter int unsigned NUM_DIGITS = CALC_NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_2s_comp,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_negative,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam int unsigned BCD_WIDTH = 4 * NUM_DIGITS;

  conv_state_t state, state_next;

  logic [CNT_WIDTH-1:0]            cnt;
  logic [DATA_WIDTH-1:0]           mag;
  logic [BCD_WIDTH-1:0]            acc;
  logic [BCD_WIDTH-1:0]            acc_adj;
  logic [BCD_WIDTH+DATA_WIDTH-1:0] shift_word;
  logic                            neg_pending;
  logic                            accept;
  logic                            last_shift;
  logic                            is_negative_in;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .digit    (acc[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end

  // The adjusted top digit's MSB falls off the shift; the digit-count bound guarantees it is zero.
  assign shift_word     = {acc_adj, mag} << 1;
  assign accept         = (state == IDLE) && i_valid;
  assign last_shift     = (state == CONVERT) && (cnt == CNT_WIDTH'(1));
  assign is_negative_in = i_2s_comp && i_data[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mag         <= '0;
      acc         <= '0;
      neg_pending <= 1'b0;
      o_bcd       <= '0;
      o_negative  <= 1'b0;
    end else if (accept) begin
      cnt         <= CNT_WIDTH'(DATA_WIDTH);
      acc         <= '0;
      neg_pending <= is_negative_in;
      mag         <= is_negative_in ? (~i_data + DATA_WIDTH'(1)) : i_data;
    end else if (state == CONVERT) begin
      {acc, mag} <= shift_word;
      cnt        <= cnt - CNT_WIDTH'(1);
      if (last_shift) begin
        o_bcd      <= shift_word[BCD_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        o_negative <= neg_pending;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: directed corner cases plus
// randomised words compared against a decimal reference model.
module tb_bin_to_bcd_converter;

  localparam int unsigned DW = 16;
  localparam int unsigned ND = 5;
  localparam int unsigned BW = 4 * ND;
  localparam int unsigned TIMEOUT = 60;

  localparam logic [DW-1:0] D_TAB [6] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 16'h0000};
  localparam logic          S_TAB [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [BW-1:0] E_TAB [6] = '{20'h65535, 20'h32768, 20'h00001, 20'h32768, 20'h00000, 20'h00000};
  localparam logic          N_TAB [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] i_data;
  logic          i_2s_comp;
  logic          i_valid;
  logic          o_ready;
  logic [BW-1:0] o_bcd;
  logic          o_negative;
  logic          o_valid;
  logic          i_ready;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_converter #(
    .DATA_WIDTH (DW),
    .NUM_DIGITS (ND)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     (i_data),
    .i_2s_comp  (i_2s_comp),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_bcd      (o_bcd),
    .o_negative (o_negative),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: interpret the word as an integer, split sign, peel digits with % 10.
  function automatic void ref_model(input logic [DW-1:0] d, input logic s,
                                    output logic [BW-1:0] bcd, output logic neg);
    longint          v;
    longint unsigned m;
    v = longint'(d);
    if (s && v >= (longint'(1) << (DW - 1))) v = v - (longint'(1) << DW);
    neg = (v < 0);
    m   = (v < 0) ? longint'(-v) : v;
    bcd = '0;
    for (int unsigned k = 0; k < ND; k++) begin
      bcd[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  // Called on a negedge with o_ready expected high; returns on the negedge o_valid is seen
  // (or when the cycle budget expires), with cycles counted from the driving negedge.
  task automatic run_word(input logic [DW-1:0] d, input logic s,
                          output logic [BW-1:0] bcd, output logic neg, output int cycles);
    i_data    = d;
    i_2s_comp = s;
    i_valid   = 1'b1;
    cycles    = 0;
    do begin
      @(negedge clk);
      if (cycles == 0) begin
        i_valid   = 1'b0;
        i_data    = DW'($urandom);
        i_2s_comp = 1'($urandom);
      end
      cycles++;
    end while (!o_valid && cycles < TIMEOUT);
    bcd = o_bcd;
    neg = o_negative;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_bcd !== '0) begin errors++; $display("FAIL reset_bcd: got %h expected 0", o_bcd); end
    checks++; if (o_negative !== 1'b0) begin errors++; $display("FAIL reset_negative: got %b expected 0", o_negative); end
    rst_n = 1'b1;
  endtask

  task automatic test_corners();
    logic [BW-1:0] bcd;
    logic          neg;
    int            cycles;
    i_ready = 1'b1;
    for (int unsigned t = 0; t < 6; t++) begin
      run_word(D_TAB[t], S_TAB[t], bcd, neg, cycles);
      checks++; if (cycles !== DW + 1) begin errors++; $display("FAIL corner%0d_latency: got %0d expected %0d", t, cycles, DW + 1); end
      checks++; if (bcd !== E_TAB[t]) begin errors++; $display("FAIL corner%0d_bcd: got %h expected %h", t, bcd, E_TAB[t]); end
      checks++; if (neg !== N_TAB[t]) begin errors++; $display("FAIL corner%0d_negative: got %b expected %b", t, neg, N_TAB[t]); end
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++; $display("FAIL corner%0d_handshake: got valid=%b ready=%b expected valid=0 ready=1", t, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] bcd;
    logic          neg;
    int            cycles;
    time           t0, t1;
    i_ready = 1'b1;
    t0 = $time;
    run_word(DW'(1234), 1'b0, bcd, neg, cycles);
    checks++; if (bcd !== 20'h01234) begin errors++; $display("FAIL b2b_first_bcd: got %h expected 01234", bcd); end
    @(negedge clk);
    t1 = $time;
    checks++; if (o_ready !== 1'b1 || (t1 - t0) !== 64'(10 * (DW + 2))) begin
      errors++; $display("FAIL b2b_throughput: got ready=%b period=%0t expected ready=1 period=%0d", o_ready, t1 - t0, 10 * (DW + 2));
    end
    run_word(DW'(-7), 1'b1, bcd, neg, cycles);
    checks++; if (bcd !== 20'h00007 || neg !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got bcd=%h neg=%b expected bcd=00007 neg=1", bcd, neg);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] bcd;
    logic          neg;
    int            cycles;
    i_ready = 1'b0;
    run_word(DW'(12345), 1'b0, bcd, neg, cycles);
    checks++; if (bcd !== 20'h12345 || cycles !== DW + 1) begin
      errors++; $display("FAIL bp_result: got bcd=%h cycles=%0d expected bcd=12345 cycles=%0d", bcd, cycles, DW + 1);
    end
    for (int unsigned k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_data  = DW'($urandom);
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_bcd !== 20'h12345) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%b ready=%b bcd=%h expected valid=1 ready=0 bcd=12345", k, o_valid, o_ready, o_bcd);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid);
    end
    @(negedge clk);
    checks++; if (o_bcd !== 20'h12345 || o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_result_held: got bcd=%h ready=%b expected bcd=12345 ready=1", o_bcd, o_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] bcd;
    logic          neg;
    int            cycles;
    i_ready = 1'b1;
    run_word(16'hFFFF, 1'b1, bcd, neg, cycles);
    checks++; if (neg !== 1'b1) begin errors++; $display("FAIL rst_pre_negative: got %b expected 1", neg); end
    @(negedge clk);
    i_data    = DW'(999);
    i_2s_comp = 1'b0;
    i_valid   = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_bcd !== '0 || o_negative !== 1'b0) begin
      errors++; $display("FAIL rst_async: got ready=%b valid=%b bcd=%h neg=%b expected 1 0 00000 0", o_ready, o_valid, o_bcd, o_negative);
    end
    repeat (3) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_held_valid: got %b expected 0", o_valid); end
    rst_n = 1'b1;
    run_word(DW'(42), 1'b0, bcd, neg, cycles);
    checks++; if (bcd !== 20'h00042 || neg !== 1'b0 || cycles !== DW + 1) begin
      errors++; $display("FAIL rst_after_42: got bcd=%h neg=%b cycles=%0d expected 00042 0 %0d", bcd, neg, cycles, DW + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [BW-1:0] bcd, exp_bcd;
    logic          neg, exp_neg;
    logic [DW-1:0] d;
    logic          s;
    int            cycles;
    int unsigned   stall;
    for (int unsigned n = 0; n < 2000; n++) begin
      d = DW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: d = '0;
          1: d = '1;
          2: d = {1'b1, {(DW - 1){1'b0}}};
          default: d = {1'b0, {(DW - 1){1'b1}}};
        endcase
      end
      s       = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      ref_model(d, s, exp_bcd, exp_neg);
      run_word(d, s, bcd, neg, cycles);
      checks++;
      if (bcd !== exp_bcd || neg !== exp_neg || cycles !== DW + 1) begin
        errors++;
        $display("FAIL rand%0d d=%h s=%b: got bcd=%h neg=%b cycles=%0d expected bcd=%h neg=%b cycles=%0d",
                 n, d, s, bcd, neg, cycles, exp_bcd, exp_neg, DW + 1);
      end
      if (!i_ready) begin
        stall = $urandom_range(1, 4);
        repeat (stall) begin
          @(negedge clk);
          checks++;
          if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_bcd !== exp_bcd) begin
            errors++; $display("FAIL rand%0d_stall: got valid=%b ready=%b bcd=%h expected valid=1 ready=0 bcd=%h", n, o_valid, o_ready, o_bcd, exp_bcd);
          end
        end
        i_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
        errors++; $display("FAIL rand%0d_release: got ready=%b valid=%b expected ready=1 valid=0", n, o_ready, o_valid);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    i_data    = '0;
    i_2s_comp = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
